rr_grant_fsm: RTL and testbench

//   Round-robin arbiter that shares one resource among N requesters.

---
 rtl/rr_grant_fsm.sv | 118 +++++++++++
 tb/tb_rr_grant_fsm.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_grant_fsm.sv
// Round-robin arbiter for one shared single-owner resource: IDLE/GRANT/GAP controller
// with a rotating priority pointer and a hold-time watchdog. All outputs are registered.
module rr_grant_fsm #(
   parameter int N        = 4,
   parameter int MAX_HOLD = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         req,
   input  logic                 done,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] gnt_id,
   output logic                 busy,
   output logic                 timeout
);
   localparam int IW = $clog2(N);
   localparam int HW = $clog2(MAX_HOLD + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
   localparam logic [IW-1:0] ID_LAST   = IW'(N - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t          state, state_d;
   logic [IW-1:0]   ptr, ptr_d;
   logic [IW-1:0]   win, id_d, ptr_after;
   logic [HW-1:0]   hold_cnt, hold_d;
   logic [N-1:0]    gnt_d;
   logic            busy_d, timeout_d;
   logic            any_req, owner_req;

   // Search starts at ptr and wraps; first requester found wins.
   always_comb begin
      win     = '0;
      any_req = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!any_req && req[(int'(ptr) + k) % N]) begin
            any_req = 1'b1;
            win     = IW'((int'(ptr) + k) % N);
         end
      end
   end

   assign owner_req = req[gnt_id];
   assign ptr_after = (gnt_id == ID_LAST) ? '0 : gnt_id + 1'b1;

   always_comb begin
      state_d   = state;
      gnt_d     = gnt;
      id_d      = gnt_id;
      busy_d    = busy;
      timeout_d = 1'b0;
      ptr_d     = ptr;
      hold_d    = hold_cnt;
      case (state)
         IDLE: begin
            gnt_d  = '0;
            id_d   = '0;
            busy_d = 1'b0;
            if (any_req) begin
               state_d    = GRANT;
               gnt_d[win] = 1'b1;
               id_d       = win;
               busy_d     = 1'b1;
               hold_d     = '0;
            end
         end
         GRANT: begin
            if (hold_cnt != '1) hold_d = hold_cnt + 1'b1;
            // done beats owner withdrawal, which beats the watchdog
            if (done || !owner_req || hold_cnt == HOLD_LAST) begin
               state_d   = GAP;
               gnt_d     = '0;
               id_d      = '0;
               busy_d    = 1'b0;
               ptr_d     = ptr_after;
               timeout_d = !done && owner_req;
            end
         end
         GAP: begin
            state_d = IDLE;
            gnt_d   = '0;
            id_d    = '0;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
            id_d    = '0;
            busy_d  = 1'b0;
            hold_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         gnt      <= '0;
         gnt_id   <= '0;
         busy     <= 1'b0;
         timeout  <= 1'b0;
         ptr      <= '0;
         hold_cnt <= '0;
      end else begin
         state    <= state_d;
         gnt      <= gnt_d;
         gnt_id   <= id_d;
         busy     <= busy_d;
         timeout  <= timeout_d;
         ptr      <= ptr_d;
         hold_cnt <= hold_d;
      end
   end
endmodule

// File: tb/tb_rr_grant_fsm.sv
// Scoreboard bench for rr_grant_fsm: stimulus queues expected grants (owner, hold length,
// timeout flag); a negedge monitor pops and checks each grant as the DUT presents it.
module tb_rr_grant_fsm;
   localparam int N = 4;
   localparam int MAX_HOLD = 8;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] req   = '0;
   logic         done  = 1'b0;
   logic [N-1:0] gnt;
   logic [1:0]   gnt_id;
   logic         busy, timeout;

   always #5 clk = ~clk;

   rr_grant_fsm #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .done(done),
      .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .timeout(timeout)
   );

   // len = expected cycles with gnt high; 0 means the grant is cut by reset
   typedef struct {
      int id;
      int len;
      bit tmo;
   } exp_t;

   exp_t q[$];
   int   checks = 0, errors = 0;
   int   stall_req = 0, stall_seen = 0;
   exp_t cur;
   bit   active = 1'b0, had_prev = 1'b0;
   int   len = 0, zeros = 0;

   function automatic void chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Monitor: sole owner of the check counters.
   always begin
      @(negedge clk or negedge rst_n);
      if (stall_req != stall_seen) begin
         chk("wait_bound", stall_req - stall_seen, 0);
         stall_seen = stall_req;
      end
      if (clk) begin
         #1;
         chk("async_rst_gnt", int'(gnt), 0);
         chk("async_rst_busy", int'(busy), 0);
         chk("async_rst_id", int'(gnt_id), 0);
         chk("async_rst_tmo", int'(timeout), 0);
      end else if (!rst_n) begin
         chk("rst_gnt", int'(gnt), 0);
         chk("rst_busy", int'(busy), 0);
         if (active) chk("abort_len", len == 0 ? -1 : cur.len, 0);
         active = 1'b0; had_prev = 1'b0; zeros = 0; len = 0;
      end else if (gnt != '0) begin
         chk("busy_on", int'(busy), 1);
         if (!active) begin
            if (q.size() == 0) begin
               chk("spurious_grant", int'(gnt), 0);
               cur = '{int'(gnt_id), -1, 1'b0};
            end else begin
               cur = q.pop_front();
               chk("gnt_onehot", int'(gnt), 1 << cur.id);
               chk("gnt_id", int'(gnt_id), cur.id);
               if (had_prev) chk("gap_ge2", int'(zeros >= 2), 1);
            end
            active = 1'b1;
            len = 1;
         end else begin
            len++;
            chk("gnt_stable", int'(gnt), 1 << cur.id);
         end
      end else begin
         chk("busy_off", int'(busy), 0);
         chk("id_zero", int'(gnt_id), 0);
         if (active) begin
            chk("hold_len", len, cur.len);
            chk("timeout_pulse", int'(timeout), int'(cur.tmo));
            active = 1'b0; had_prev = 1'b1; zeros = 1;
         end else begin
            chk("timeout_idle", int'(timeout), 0);
            zeros++;
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_gnt();
      int c = 0;
      while (gnt == '0 && c < 12) begin tick(); c++; end
      if (gnt == '0) stall_req++;
   endtask

   task automatic wait_rel(input int bound);
      int c = 0;
      while (gnt != '0 && c < bound) begin tick(); c++; end
      if (gnt != '0) stall_req++;
   endtask

   task automatic push(input int id, input int l, input bit tmo);
      q.push_back('{id, l, tmo});
   endtask

   task automatic serve_one(); // pulse done one cycle after grant and drop requests
      wait_gnt();
      done = 1'b1; req = '0;
      tick();
      done = 1'b0;
      tick(3);
   endtask

   initial begin
      tick(3);
      rst_n = 1'b1;
      tick(2);

      // single requester, served by done
      push(1, 1, 1'b0);
      req = 4'b0010;
      serve_one();

      // full rotation from ptr=0 after reset
      rst_n = 1'b0;
      @(negedge clk); #1 rst_n = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) push(i % N, 1, 1'b0);
      req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         wait_gnt();
         done = 1'b1;
         tick();
         done = 1'b0;
      end
      req = '0;
      tick(3);

      // watchdog: held 8 cycles, then ptr=1 favours requester 1 over 0
      push(0, MAX_HOLD, 1'b1);
      req = 4'b0001;
      wait_gnt();
      wait_rel(12);
      req = '0;
      tick(2);
      push(1, 1, 1'b0);
      req = 4'b0011;
      serve_one();

      // owner 2 withdraws mid-grant, pending 0 served next
      push(2, 3, 1'b0);
      req = 4'b0101;
      wait_gnt();
      tick(2);
      req = 4'b0001;
      push(0, 1, 1'b0);
      wait_rel(4);
      serve_one();

      // done coincides with the last hold cycle: no timeout
      push(1, MAX_HOLD, 1'b0);
      req = 4'b0010;
      wait_gnt();
      tick(MAX_HOLD - 1);
      done = 1'b1;
      tick();
      done = 1'b0; req = '0;
      tick(3);

      // async reset mid-grant, then ptr back at 0
      push(2, 0, 1'b0);
      req = 4'b0100;
      wait_gnt();
      tick(2);
      #2 rst_n = 1'b0;
      @(negedge clk);
      #1;
      req = 4'b0110;
      push(1, 1, 1'b0);
      rst_n = 1'b1;
      serve_one();

      for (int c = 0; c < 20 && (q.size() != 0 || active); c++) tick();
      if (q.size() != 0 || active) stall_req++;
      @(negedge clk); #1;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no end expected end");
      $fatal(1, "time limit");
   end
endmodule
